// File: rtl/msg_drain_arbiter_pkg.sv
// Shared constants for the message drain arbiter: FSM encodings, header layout, default widths.
// The header word is only emitted when MSG_ARB_HEADER_EN is defined.
package msg_drain_arbiter_pkg;

  localparam int unsigned DEF_LEN_W  = 8;
  localparam int unsigned DEF_DATA_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HDR   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int unsigned HDR_SRC_BIT = 15;
  localparam int unsigned HDR_PAR_BIT = 14;
  localparam int unsigned HDR_LEN_W   = 8;

  function automatic logic [15:0] make_header(logic src, logic par, logic [HDR_LEN_W-1:0] len);
    logic [15:0] hdr;
    hdr                = '0;
    hdr[HDR_SRC_BIT]   = src;
    hdr[HDR_PAR_BIT]   = par;
    hdr[HDR_LEN_W-1:0] = len;
    return hdr;
  endfunction

endpackage

// File: rtl/msg_drain_arbiter_if.sv
// Source-FIFO and MAIN-FIFO handshake bundle; master = arbiter, slave = FIFO side.
interface msg_drain_arbiter_if
  import msg_drain_arbiter_pkg::*;
#(
  parameter int unsigned LEN_W  = DEF_LEN_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic [1:0]        SRC_RDY;
  logic [LEN_W-1:0]  SRC_LEN0;
  logic [LEN_W-1:0]  SRC_LEN1;
  logic [1:0]        SRC_PAR;
  logic [DATA_W-1:0] SRC_Q0;
  logic [DATA_W-1:0] SRC_Q1;
  logic [1:0]        SRC_RD;
  logic              MAIN_AFULL;
  logic [DATA_W-1:0] MAIN_DATA;
  logic              MAIN_WR;

  modport master (
    input  SRC_RDY, SRC_LEN0, SRC_LEN1, SRC_PAR, SRC_Q0, SRC_Q1, MAIN_AFULL,
    output SRC_RD, MAIN_DATA, MAIN_WR
  );

  modport slave (
    output SRC_RDY, SRC_LEN0, SRC_LEN1, SRC_PAR, SRC_Q0, SRC_Q1, MAIN_AFULL,
    input  SRC_RD, MAIN_DATA, MAIN_WR
  );

endinterface

// File: rtl/msg_drain_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the last-served pointer moves only on the done strobe.
module msg_drain_arbiter_rr_arb2
  import msg_drain_arbiter_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_id,
  output logic [1:0] gnt
);

  // Reset as "source 1 served last" so source 0 wins the first tie.
  logic last_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_q <= 1'b1;
    end else if (done) begin
      last_q <= done_id;
    end
  end

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/msg_drain_arbiter.sv
// Moves complete messages from two source FIFOs into MAIN FIFO, round-robin per message.
// Define MSG_ARB_HEADER_EN to prepend a {src, parity, 6'b0, len} header word.
module msg_drain_arbiter
  import msg_drain_arbiter_pkg::*;
#(
  parameter int unsigned LEN_W  = DEF_LEN_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic               CLK,
  input  logic               RST,
  msg_drain_arbiter_if.master bus,
  output logic [1:0]         GRANT,
  output logic               BUSY,
  output logic               MSG_DONE,
  output logic [1:0]         state_mon
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             src_id_q, src_id_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             par_q, par_d;
  logic [LEN_W-1:0] words_left_q, words_left_d;
  logic             rd_pend_q, rd_pend_d;

  logic [1:0]       arb_gnt;
  logic             arb_done;
  logic [LEN_W-1:0] len_sel;
  logic [1:0]       src_rd;
  logic             hdr_wr;

  msg_drain_arbiter_rr_arb2 u_rr_arb2 (
    .CLK     (CLK),
    .RST     (RST),
    .req     (bus.SRC_RDY),
    .done    (arb_done),
    .done_id (src_id_q),
    .gnt     (arb_gnt)
  );

  assign len_sel = arb_gnt[1] ? bus.SRC_LEN1 : bus.SRC_LEN0;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    src_id_d     = src_id_q;
    len_d        = len_q;
    par_d        = par_q;
    words_left_d = words_left_q;
    src_rd       = 2'b00;
    hdr_wr       = 1'b0;
    arb_done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          grant_d      = arb_gnt;
          src_id_d     = arb_gnt[1];
          len_d        = len_sel;
          par_d        = bus.SRC_PAR[arb_gnt[1]];
          words_left_d = len_sel >> 1;
`ifdef MSG_ARB_HEADER_EN
          state_d      = ST_HDR;
`else
          state_d      = ST_DRAIN;
`endif
        end
      end
`ifdef MSG_ARB_HEADER_EN
      ST_HDR: begin
        if (!bus.MAIN_AFULL) begin
          hdr_wr  = 1'b1;
          state_d = ST_DRAIN;
        end
      end
`endif
      ST_DRAIN: begin
        // A read issued last cycle still writes this cycle, so leaving here is safe.
        if (words_left_q != '0) begin
          if (!bus.MAIN_AFULL) begin
            src_rd       = grant_q;
            words_left_d = words_left_q - LEN_W'(1);
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        arb_done = 1'b1;
        grant_d  = 2'b00;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rd_pend_d = |src_rd;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'b00;
      src_id_q     <= 1'b0;
      len_q        <= '0;
      par_q        <= 1'b0;
      words_left_q <= '0;
      rd_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      src_id_q     <= src_id_d;
      len_q        <= len_d;
      par_q        <= par_d;
      words_left_q <= words_left_d;
      rd_pend_q    <= rd_pend_d;
    end
  end

  logic [DATA_W-1:0] main_data;

  always_comb begin
    main_data = '0;
    if (rd_pend_q) begin
      main_data = src_id_q ? bus.SRC_Q1 : bus.SRC_Q0;
    end
`ifdef MSG_ARB_HEADER_EN
    else if (hdr_wr) begin
      main_data = DATA_W'(make_header(src_id_q, par_q, len_q[HDR_LEN_W-1:0]));
    end
`endif
  end

`ifndef MSG_ARB_HEADER_EN
  logic unused_hdr;
  assign unused_hdr = ^{len_q, par_q};
`endif

  assign bus.SRC_RD    = src_rd;
  assign bus.MAIN_WR   = rd_pend_q | hdr_wr;
  assign bus.MAIN_DATA = main_data;

  assign GRANT     = grant_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign MSG_DONE  = (state_q == ST_DONE);
  assign state_mon = state_q;

endmodule

// File: tb/tb_msg_drain_arbiter.sv
// Randomized scoreboard bench for msg_drain_arbiter; honours MSG_ARB_HEADER_EN like the RTL.
module tb_msg_drain_arbiter;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  msg_drain_arbiter_if #(.LEN_W(8), .DATA_W(16)) bus ();

  logic [1:0] GRANT;
  logic       BUSY;
  logic       MSG_DONE;
  logic [1:0] state_mon;

  msg_drain_arbiter #(.LEN_W(8), .DATA_W(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .GRANT     (GRANT),
    .BUSY      (BUSY),
    .MSG_DONE  (MSG_DONE),
    .state_mon (state_mon)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          exp_src_q[$];
  logic [15:0] src0_q[$];
  logic [15:0] src1_q[$];
  int          rd_cnt[2];
  int          exp_rd[2];
  int          last_served;
  bit          mon_en;
  int          afull_hold;
  int          afull_pct;
  logic [1:0]  rd_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] hdr_word(input int s, input bit par, input logic [7:0] len);
    logic b;
    b = s[0];
    return {b, par, 6'b000000, len};
  endfunction

  function automatic logic [7:0] rand_len();
    if ($urandom_range(9) == 0) return 8'($urandom_range(1, 7) * 2 + 1);
    return 8'($urandom_range(1, 8) * 2);
  endfunction

  // Queue a message at a source and record what MAIN must see, in service order.
  task automatic issue(input int s, input logic [7:0] len, input bit par, input bit fixed);
    logic [15:0] w;
`ifdef MSG_ARB_HEADER_EN
    exp_q.push_back(hdr_word(s, par, len));
`endif
    for (int i = 0; i < int'(len >> 1); i++) begin
      w = fixed ? 16'(32'h1111 * (i + 1)) : 16'($urandom);
      exp_q.push_back(w);
      if (s == 0) src0_q.push_back(w);
      else src1_q.push_back(w);
    end
    exp_rd[s] += int'(len >> 1);
    exp_src_q.push_back(s);
    if (s == 0) bus.SRC_LEN0 = len;
    else bus.SRC_LEN1 = len;
    bus.SRC_PAR[s] = par;
    bus.SRC_RDY[s] = 1'b1;
  endtask

  // One clock of the source/MAIN FIFO model: reads seen before the edge take effect after it.
  task automatic tick();
    @(negedge CLK);
    rd_s = bus.SRC_RD;
    @(posedge CLK);
    #1;
    for (int s = 0; s < 2; s++) begin
      if (rd_s[s]) begin
        rd_cnt[s]++;
        bus.SRC_RDY[s] = 1'b0;
        if (s == 0) bus.SRC_LEN0 = 8'($urandom);
        else bus.SRC_LEN1 = 8'($urandom);
        checks++;
        if (s == 0 && src0_q.size() > 0) bus.SRC_Q0 = src0_q.pop_front();
        else if (s == 1 && src1_q.size() > 0) bus.SRC_Q1 = src1_q.pop_front();
        else begin
          errors++;
          $display("FAIL src_underflow source=%0d actual=read required=no_read", s);
        end
      end
    end
    if (afull_hold > 0) begin
      bus.MAIN_AFULL = 1'b1;
      afull_hold--;
    end else begin
      bus.MAIN_AFULL = ($urandom_range(99) < afull_pct);
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    exp_src_q.delete();
    src0_q.delete();
    src1_q.delete();
    for (int s = 0; s < 2; s++) exp_rd[s] = rd_cnt[s];
    bus.SRC_RDY    = 2'b00;
    bus.MAIN_AFULL = 1'b0;
    afull_hold     = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_grant", 32'(GRANT), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(MSG_DONE), 32'd0);
    chk("rst_state", 32'(state_mon), 32'd0);
    chk("rst_src_rd", 32'(bus.SRC_RD), 32'd0);
    chk("rst_main_wr", 32'(bus.MAIN_WR), 32'd0);
    chk("rst_main_data", 32'(bus.MAIN_DATA), 32'd0);
  endtask

  task automatic reset_pulse(input bit check);
    mon_en = 1'b0;
    RST    = 1'b0;
    #1;
    if (check) check_reset_outputs();
    flush_model();
    last_served = 1;
    repeat (2) tick();
    RST    = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || exp_src_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_words_left required=0", exp_q.size());
      reset_pulse(1'b0);
    end
    repeat (2) tick();
    for (int s = 0; s < 2; s++) chk($sformatf("rd_count_src%0d", s), 32'(rd_cnt[s]), 32'(exp_rd[s]));
  endtask

  task automatic wait_rd(input int s, input int target);
    int n = 0;
    while (rd_cnt[s] < target && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL read_timeout source=%0d actual=%0d required=%0d", s, rd_cnt[s], target);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int          a;
    int          mode;
    logic [7:0]  l0;
    logic [7:0]  l1;
    RST            = 1'b0;
    mon_en         = 1'b0;
    afull_hold     = 0;
    afull_pct      = 0;
    last_served    = 1;
    rd_cnt[0]      = 0;
    rd_cnt[1]      = 0;
    exp_rd[0]      = 0;
    exp_rd[1]      = 0;
    bus.SRC_RDY    = 2'b00;
    bus.SRC_LEN0   = 8'd0;
    bus.SRC_LEN1   = 8'd0;
    bus.SRC_PAR    = 2'b00;
    bus.SRC_Q0     = 16'd0;
    bus.SRC_Q1     = 16'd0;
    bus.MAIN_AFULL = 1'b0;
    #1;
    check_reset_outputs();

    fork
      begin : monitor
        logic [15:0] w;
        int          s;
        bit          prev_done = 1'b0;
        forever begin
          @(negedge CLK);
          if (mon_en) begin
            if (bus.MAIN_WR) begin
              if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_write actual=%0h required=no_write", bus.MAIN_DATA);
              end else begin
                w = exp_q.pop_front();
                chk("main_data", 32'(bus.MAIN_DATA), 32'(w));
              end
            end
            if (MSG_DONE) begin
              chk("done_single_pulse", 32'(prev_done), 32'd0);
              if (exp_src_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_done actual=1 required=0");
              end else begin
                s = exp_src_q.pop_front();
                chk("done_grant", 32'(GRANT), 32'(1 << s));
              end
            end
            if (bus.MAIN_AFULL) chk("rd_under_afull", 32'(bus.SRC_RD), 32'd0);
`ifndef MSG_ARB_HEADER_EN
            if (state_mon == 2'd1) chk("no_hdr_state", 32'(state_mon), 32'd0);
`endif
            prev_done = MSG_DONE;
          end
        end
      end
    join_none

    repeat (2) tick();
    RST    = 1'b1;
    mon_en = 1'b1;
    tick();

    // Fixed payload, header 0x0006 when enabled.
    issue(0, 8'd6, 1'b0, 1'b1);
    last_served = 0;
    wait_idle();

    // Simultaneous requests straight after reset: source 0 must win.
    reset_pulse(1'b1);
    issue(0, 8'd2, 1'b0, 1'b0);
    issue(1, 8'd4, 1'b0, 1'b0);
    last_served = 1;
    wait_idle();

    // MAIN_AFULL burst mid-drain.
    issue(0, 8'd8, 1'b0, 1'b0);
    wait_rd(0, rd_cnt[0] + 1);
    afull_hold = 5;
    last_served = 0;
    wait_idle();

    // Length input changes right after grant; the latched length governs.
    issue(0, 8'd8, 1'b1, 1'b0);
    wait_rd(0, rd_cnt[0] + 1);
    bus.SRC_LEN0 = 8'd2;
    wait_idle();
    issue(0, 8'd2, 1'b0, 1'b0);
    wait_idle();

    // Reset with two words still to read.
    issue(1, 8'd8, 1'b0, 1'b0);
    wait_rd(1, rd_cnt[1] + 2);
    reset_pulse(1'b1);
    issue(0, 8'd4, 1'b1, 1'b0);
    last_served = 0;
    wait_idle();

    // Parity set on a short source-1 message.
    issue(1, 8'd2, 1'b1, 1'b0);
    last_served = 1;
    wait_idle();

    for (int b = 0; b < 30; b++) begin
      afull_pct = $urandom_range(0, 40);
      mode      = $urandom_range(2);
      l0        = rand_len();
      l1        = rand_len();
      if (mode == 0) begin
        a = $urandom_range(1);
        issue(a, (a == 0) ? l0 : l1, 1'($urandom), 1'b0);
        last_served = a;
      end else if (mode == 1) begin
        a = (last_served == 0) ? 1 : 0;
        issue(a, l0, 1'($urandom), 1'b0);
        issue(1 - a, l1, 1'($urandom), 1'b0);
        last_served = 1 - a;
      end else begin
        a = $urandom_range(1);
        issue(a, l0, 1'($urandom), 1'b0);
        wait_rd(a, rd_cnt[a] + 1);
        repeat ($urandom_range(0, 2)) tick();
        issue(1 - a, l1, 1'($urandom), 1'b0);
        last_served = 1 - a;
      end
      wait_idle();
    end

    afull_pct = 0;
    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
